// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller:
// scan FSM encoding, fixed segment/anode patterns and a nibble helper.
package seven_seg_scan_ctrl_pkg;

  // GAP is the tick-0 slot in which every anode is off, so the previous
  // digit's segments never ghost onto the next digit. SHOW covers the rest.
  typedef enum logic [0:0] {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_e;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Anodes are active-low; all ones means no digit is enabled.
  localparam logic [3:0] AN_OFF = 4'b1111;

  // True when the nibble is a legal BCD digit (0..9).
  function automatic logic nib_is_bcd(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/BcdTo7segment.sv
// BCD to seven-segment decoder, segment order {g,f,e,d,c,b,a}, active-high.
// Non-BCD codes decode to all segments off; callers handle them explicitly.
module BcdTo7segment (
  input  logic [3:0] bcd,
  output logic [6:0] Out
);

  // Pure lookup from BCD digit to lit segments.
  always_comb begin
    Out = 7'b0000000;
    case (bcd)
      4'd0:    Out = 7'b0111111;
      4'd1:    Out = 7'b0000110;
      4'd2:    Out = 7'b1011011;
      4'd3:    Out = 7'b1001111;
      4'd4:    Out = 7'b1100110;
      4'd5:    Out = 7'b1101101;
      4'd6:    Out = 7'b1111101;
      4'd7:    Out = 7'b0000111;
      4'd8:    Out = 7'b1111111;
      4'd9:    Out = 7'b1101111;
      default: Out = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scanner. A new value is accepted
// into a shadow register through a load/ready handshake and only becomes
// visible at a frame boundary, so a frame is never a mix of two values.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIV    = 1000,
  parameter int unsigned DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic        ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam logic [15:0] TICK_LAST  = 16'(DIV - 1);
  localparam logic [1:0]  DIGIT_LAST = 2'(DIGITS - 1);

  logic [15:0] tick_q, tick_d;
  logic [1:0]  digit_q, digit_d;
  scan_state_e state_q, state_d;

  logic [15:0] active_val_q, active_val_d;
  logic [3:0]  active_dp_q, active_dp_d;
  logic [15:0] shadow_val_q, shadow_val_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic        pending_q, pending_d;
  logic        ready_q, ready_d;

  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;

  logic        tick_wrap;
  logic        frame_end;
  logic [3:0]  nib_sel;
  logic        lead_zero;
  logic        blank_digit;
  logic [6:0]  dec_seg;

  assign tick_wrap = (tick_q == TICK_LAST);
  assign frame_end = tick_wrap && (digit_q == DIGIT_LAST);

  // Tick counter and digit index: digit advances each time the tick wraps.
  always_comb begin
    tick_d  = tick_q;
    digit_d = digit_q;
    if (tick_wrap) begin
      tick_d = 16'd0;
      if (digit_q == DIGIT_LAST) begin
        digit_d = 2'd0;
      end else begin
        digit_d = digit_q + 2'd1;
      end
    end else begin
      tick_d = tick_q + 16'd1;
    end
  end

  // Scan FSM: GAP occupies exactly tick 0 of each slot, SHOW the remainder.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_GAP: state_d = ST_SHOW;
      ST_SHOW: begin
        if (tick_wrap) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: state_d = ST_GAP;
    endcase
  end

  // Handshake: accept into shadow when ready, commit shadow only at frame end.
  // While pending, ready is low, so a capture and a commit never coincide.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pending_d    = pending_q;
    if (frame_end && pending_q) begin
      active_val_d = shadow_val_q;
      active_dp_d  = shadow_dp_q;
      pending_d    = 1'b0;
    end else begin
      active_val_d = active_val_q;
      active_dp_d  = active_dp_q;
    end
    if (load && ready_q) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end else begin
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
    end
    ready_d = ~pending_d;
  end

  // Select the active nibble for the current digit and flag leading zeros.
  always_comb begin
    nib_sel   = 4'h0;
    lead_zero = 1'b0;
    case (digit_q)
      2'd0: begin
        nib_sel   = active_val_q[3:0];
        lead_zero = 1'b0;
      end
      2'd1: begin
        nib_sel   = active_val_q[7:4];
        lead_zero = (active_val_q[15:4] == 12'h000);
      end
      2'd2: begin
        nib_sel   = active_val_q[11:8];
        lead_zero = (active_val_q[15:8] == 8'h00);
      end
      2'd3: begin
        nib_sel   = active_val_q[15:12];
        lead_zero = (active_val_q[15:12] == 4'h0);
      end
      default: begin
        nib_sel   = 4'h0;
        lead_zero = 1'b0;
      end
    endcase
  end

  assign blank_digit = blank_lz && lead_zero;

  BcdTo7segment u_bcd_dec (
    .bcd (nib_sel),
    .Out (dec_seg)
  );

  // Next display drive: dark in GAP or on a blanked digit, else the digit.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    an_d  = AN_OFF;
    if ((state_q == ST_SHOW) && !blank_digit) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = nib_is_bcd(nib_sel) ? dec_seg : SEG_DASH;
      dp_d  = active_dp_q[digit_q];
    end else begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b0;
      an_d  = AN_OFF;
    end
  end

  // Scan position and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q  <= 16'd0;
      digit_q <= 2'd0;
      state_q <= ST_GAP;
    end else begin
      tick_q  <= tick_d;
      digit_q <= digit_d;
      state_q <= state_d;
    end
  end

  // Shadow/active value registers and handshake state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val_q <= 16'h0000;
      shadow_dp_q  <= 4'b0000;
      active_val_q <= 16'h0000;
      active_dp_q  <= 4'b0000;
      pending_q    <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      ready_q      <= ready_d;
    end
  end

  // Registered display outputs, one cycle behind the scan position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b0;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign ready = ready_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with DIV=4 (16-cycle frame).
// Expected per-cycle {an,seg,dp} words are queued per frame and popped as
// the DUT produces them.
module tb_seven_seg_scan_ctrl;

  localparam int TB_DIV = 4;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks   = 0;
  int failures = 0;

  logic [11:0] sb_q[$];

  seven_seg_scan_ctrl #(.DIV(TB_DIV), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .ready    (ready),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference glyphs, {g,f,e,d,c,b,a}
  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Expected {an,seg,dp} for one slot of digit dig
  function automatic logic [11:0] exp_slot(input logic [15:0] v, input logic [3:0] d,
                                           input logic blz, input int dig, input bit gap);
    logic [3:0]  nib;
    logic [15:0] upper;
    logic [3:0]  an_e;
    if (gap) return {4'b1111, 7'b0000000, 1'b0};
    nib   = v[dig*4 +: 4];
    upper = v >> (dig*4);
    if (blz && (dig > 0) && (upper == 16'h0000)) return {4'b1111, 7'b0000000, 1'b0};
    an_e = 4'b1111;
    an_e[dig] = 1'b0;
    return {an_e, ref_glyph(nib), d[dig]};
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic blz);
    for (int dg = 0; dg < 4; dg++) begin
      sb_q.push_back(exp_slot(v, d, blz, dg, 1'b1));
      for (int t = 1; t < TB_DIV; t++) sb_q.push_back(exp_slot(v, d, blz, dg, 1'b0));
    end
  endtask

  // Drive a one-cycle load pulse starting now (called away from posedge)
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Bounded wait for ready to rise; returns at the negedge it is seen
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [11:0] want;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (an !== 4'b1111) begin failures++; $display("FAIL reset_an: got %b want 1111", an); end
    checks++; if (seg !== 7'b0000000) begin failures++; $display("FAIL reset_seg: got %b want 0000000", seg); end
    checks++; if (dp !== 1'b0) begin failures++; $display("FAIL reset_dp: got %b want 0", dp); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready); end
    rst = 1'b0;
    push_frame(16'h0000, 4'b0000, 1'b0);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      want = sb_q.pop_front();
      checks++;
      if ({an, seg, dp} !== want) begin
        failures++;
        $display("FAIL reset_frame: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  task automatic test_basic;
    logic [11:0] want;
    bit ok;
    blank_lz = 1'b0;
    do_load(16'h1234, 4'b0000);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL basic_ready_low: got %b want 0", ready); end
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_commit_timeout: got %b want 1", ok); end
    push_frame(16'h1234, 4'b0000, 1'b0);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      want = sb_q.pop_front();
      checks++;
      if ({an, seg, dp} !== want) begin
        failures++;
        $display("FAIL basic_frame: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  task automatic test_blank_lz;
    logic [11:0] want;
    bit ok;
    blank_lz = 1'b1;
    do_load(16'h0047, 4'b1010);
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL blank_commit_timeout: got %b want 1", ok); end
    push_frame(16'h0047, 4'b1010, 1'b1);
    do_load(16'h0000, 4'b0011);
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL blank0_commit_timeout: got %b want 1", ok); end
    sb_q.delete();
    push_frame(16'h0000, 4'b0011, 1'b1);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      want = sb_q.pop_front();
      checks++;
      if ({an, seg, dp} !== want) begin
        failures++;
        $display("FAIL blank0_frame: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, want[11:8], want[7:1], want[0]);
      end
    end
    do_load(16'h0047, 4'b1010);
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL blank47_commit_timeout: got %b want 1", ok); end
    push_frame(16'h0047, 4'b1010, 1'b1);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      want = sb_q.pop_front();
      checks++;
      if ({an, seg, dp} !== want) begin
        failures++;
        $display("FAIL blank47_frame: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, want[11:8], want[7:1], want[0]);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_dash;
    logic [11:0] want;
    bit ok;
    blank_lz = 1'b0;
    do_load(16'h00A0, 4'b0000);
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL dash_commit_timeout: got %b want 1", ok); end
    push_frame(16'h00A0, 4'b0000, 1'b0);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      want = sb_q.pop_front();
      checks++;
      if ({an, seg, dp} !== want) begin
        failures++;
        $display("FAIL dash_frame: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  task automatic test_ignore_busy;
    logic [11:0] want;
    bit ok;
    do_load(16'h1111, 4'b0000);
    value = 16'h2222;
    load  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ignore_ready_low: got %b want 0", ready); end
    load = 1'b0;
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ignore_commit_timeout: got %b want 1", ok); end
    push_frame(16'h1111, 4'b0000, 1'b0);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      want = sb_q.pop_front();
      checks++;
      if ({an, seg, dp} !== want) begin
        failures++;
        $display("FAIL ignore_old_frame: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, want[11:8], want[7:1], want[0]);
      end
    end
    do_load(16'h2222, 4'b0100);
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL reload_commit_timeout: got %b want 1", ok); end
    push_frame(16'h2222, 4'b0100, 1'b0);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      want = sb_q.pop_front();
      checks++;
      if ({an, seg, dp} !== want) begin
        failures++;
        $display("FAIL reload_frame: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  task automatic test_boundary_load;
    logic [11:0] want;
    bit ok;
    do_load(16'h5678, 4'b0000);
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bnd_commit_timeout: got %b want 1", ok); end
    // Now just after the commit edge: advance to the last tick of digit 3
    repeat (15) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL bnd_ready_before: got %b want 1", ready); end
    do_load(16'h9012, 4'b0001);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL bnd_ready_after: got %b want 0", ready); end
    push_frame(16'h5678, 4'b0000, 1'b0);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      want = sb_q.pop_front();
      checks++;
      if ({an, seg, dp} !== want) begin
        failures++;
        $display("FAIL bnd_old_frame: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, want[11:8], want[7:1], want[0]);
      end
    end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL bnd_ready_commit: got %b want 1", ready); end
    push_frame(16'h9012, 4'b0001, 1'b0);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      want = sb_q.pop_front();
      checks++;
      if ({an, seg, dp} !== want) begin
        failures++;
        $display("FAIL bnd_new_frame: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, want[11:8], want[7:1], want[0]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [11:0] want;
    // Entered just after a frame-boundary edge with nothing pending
    do_load(16'h3456, 4'b1111);
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++; if (an !== 4'b1011) begin failures++; $display("FAIL mid_pre_digit2: got %b want 1011", an); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL mid_pre_pending: got %b want 0", ready); end
    rst = 1'b1;
    #1;
    checks++; if (an !== 4'b1111) begin failures++; $display("FAIL mid_rst_an: got %b want 1111", an); end
    checks++; if (seg !== 7'b0000000) begin failures++; $display("FAIL mid_rst_seg: got %b want 0000000", seg); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready: got %b want 1", ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_frame(16'h0000, 4'b0000, 1'b0);
    push_frame(16'h0000, 4'b0000, 1'b0);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      want = sb_q.pop_front();
      checks++;
      if ({an, seg, dp} !== want) begin
        failures++;
        $display("FAIL mid_after_frame: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, want[11:8], want[7:1], want[0]);
      end
    end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_after_ready: got %b want 1", ready); end
  endtask

  initial begin
    rst      = 1'b0;
    load     = 1'b0;
    value    = 16'h0000;
    dp_in    = 4'b0000;
    blank_lz = 1'b0;
    test_reset();
    test_basic();
    test_blank_lz();
    test_dash();
    test_ignore_busy();
    test_boundary_load();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
